// File: rtl/class_argmax.sv
// Streaming argmax over NUM_CLASSES signed scores; result registered 1 cycle after the last beat.
// Backpressure: score_ready drops while a result waits in HOLD until result_ready is seen.
// Optional build macro ARGMAX_MARGIN_EN adds second-best tracking, margin and low_conf.
module class_argmax #(
  parameter int NUM_CLASSES   = 10,
  parameter int SCORE_W       = 16,
  parameter int IDX_W         = 4,
  parameter int MARGIN_THRESH = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               score_valid,
  output logic               score_ready,
  input  logic [SCORE_W-1:0] score_data,
  input  logic               score_last,
  output logic               result_valid,
  input  logic               result_ready,
  output logic [IDX_W-1:0]   output_index,
  output logic [SCORE_W-1:0] best_score,
  output logic               len_err,
  output logic [SCORE_W:0]   margin,
  output logic               low_conf
);

  typedef enum logic {ACCUM, HOLD} state_e;

  localparam logic [IDX_W:0]   NUM_C   = (IDX_W+1)'(NUM_CLASSES);
  localparam logic [IDX_W-1:0] CNT_MAX = '1;

  state_e                     state_q, state_d;
  logic                       rdy_q, rdy_d;
  logic [IDX_W-1:0]           cnt_q, cnt_d;
  logic [IDX_W-1:0]           cand_idx_q, cand_idx_d;
  logic signed [SCORE_W-1:0]  cand_score_q, cand_score_d;
  logic [IDX_W-1:0]           out_idx_q, out_idx_d;
  logic [SCORE_W-1:0]         best_q, best_d;
  logic                       len_err_q, len_err_d;
  logic signed [SCORE_W-1:0]  data_s;
  logic                       accept;
  logic                       first_beat;
  logic                       in_range;
  logic [IDX_W:0]             beat_cnt;

  assign data_s     = score_data;
  assign accept     = score_valid && rdy_q;
  assign first_beat = (cnt_q == '0);
  assign in_range   = ({1'b0, cnt_q} < NUM_C);
  assign beat_cnt   = {1'b0, cnt_q} + 1'b1;

`ifdef ARGMAX_MARGIN_EN
  logic signed [SCORE_W-1:0] sec_q, sec_d;
  logic                      sec_vld_q, sec_vld_d;
  logic [SCORE_W:0]          margin_q, margin_d;
  logic                      low_q, low_d;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cand_idx_d   = cand_idx_q;
    cand_score_d = cand_score_q;
    out_idx_d    = out_idx_q;
    best_d       = best_q;
    len_err_d    = len_err_q;
`ifdef ARGMAX_MARGIN_EN
    sec_d        = sec_q;
    sec_vld_d    = sec_vld_q;
    margin_d     = margin_q;
    low_d        = low_q;
`endif
    case (state_q)
      ACCUM: begin
        if (accept) begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
          if (first_beat) begin
            cand_idx_d   = '0;
            cand_score_d = data_s;
`ifdef ARGMAX_MARGIN_EN
            sec_vld_d    = 1'b0;
`endif
          end else if (in_range) begin
            if (data_s > cand_score_q) begin
              cand_idx_d   = cnt_q;
              cand_score_d = data_s;
`ifdef ARGMAX_MARGIN_EN
              sec_d        = cand_score_q;
              sec_vld_d    = 1'b1;
            end else if (!sec_vld_q || data_s > sec_q) begin
              // An empty second slot acts as minus infinity.
              sec_d        = data_s;
              sec_vld_d    = 1'b1;
`endif
            end
          end
          if (score_last) begin
            out_idx_d = cand_idx_d;
            best_d    = cand_score_d;
            len_err_d = (beat_cnt != NUM_C);
`ifdef ARGMAX_MARGIN_EN
            margin_d  = sec_vld_d ? ({cand_score_d[SCORE_W-1], cand_score_d} -
                                     {sec_d[SCORE_W-1], sec_d}) : '0;
            low_d     = (margin_d < (SCORE_W+1)'(MARGIN_THRESH));
`endif
            cnt_d     = '0;
            state_d   = HOLD;
          end
        end
      end
      HOLD: begin
        if (result_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
    rdy_d = (state_d == ACCUM);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ACCUM;
      rdy_q        <= 1'b0;
      cnt_q        <= '0;
      cand_idx_q   <= '0;
      cand_score_q <= '0;
      out_idx_q    <= '0;
      best_q       <= '0;
      len_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rdy_q        <= rdy_d;
      cnt_q        <= cnt_d;
      cand_idx_q   <= cand_idx_d;
      cand_score_q <= cand_score_d;
      out_idx_q    <= out_idx_d;
      best_q       <= best_d;
      len_err_q    <= len_err_d;
    end
  end

`ifdef ARGMAX_MARGIN_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sec_q     <= '0;
      sec_vld_q <= 1'b0;
      margin_q  <= '0;
      low_q     <= 1'b0;
    end else begin
      sec_q     <= sec_d;
      sec_vld_q <= sec_vld_d;
      margin_q  <= margin_d;
      low_q     <= low_d;
    end
  end

  assign margin   = margin_q;
  assign low_conf = low_q;
`else
  assign margin   = '0;
  assign low_conf = 1'b0;
`endif

  assign score_ready  = rdy_q;
  assign result_valid = (state_q == HOLD);
  assign output_index = out_idx_q;
  assign best_score   = best_q;
  assign len_err      = len_err_q;

endmodule

// File: tb/tb_class_argmax.sv
// Directed bench for class_argmax: vector table plus back-pressure and mid-vector reset sequences.
// Expected margin/low_conf follow the ARGMAX_MARGIN_EN build macro.
module tb_class_argmax;

  localparam int NV = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        score_valid = 1'b0;
  logic        score_ready;
  logic [15:0] score_data = '0;
  logic        score_last = 1'b0;
  logic        result_valid;
  logic        result_ready = 1'b1;
  logic [3:0]  output_index;
  logic [15:0] best_score;
  logic        len_err;
  logic [16:0] margin;
  logic        low_conf;

  int checks = 0;
  int errors = 0;

  class_argmax #(.NUM_CLASSES(10), .SCORE_W(16), .IDX_W(4), .MARGIN_THRESH(64)) dut (
    .clk(clk), .rst(rst),
    .score_valid(score_valid), .score_ready(score_ready),
    .score_data(score_data), .score_last(score_last),
    .result_valid(result_valid), .result_ready(result_ready),
    .output_index(output_index), .best_score(best_score),
    .len_err(len_err), .margin(margin), .low_conf(low_conf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]        n;
    logic [11:0][15:0] sc;
    logic [3:0]        idx;
    logic [15:0]       best;
    logic              len;
    logic [16:0]       mg;
    logic              low;
  } vec_t;

  vec_t vt [NV];

  int sc_tab [NV][12] = '{
    '{5, -3, 9, 2, 0, 1, 7, 9, -8, 4, 0, 0},
    '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, 0, 0},
    '{3, 1, 4, 1, 5, 9, 2, 0, 0, 0, 0, 0},
    '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 1000, 2},
    '{100, 40, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
    '{200, 40, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
    '{-5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
    '{-32768, -32768, -32768, 32767, -32768, -32768, -32768, -32768, -32768, -32768, 0, 0},
    '{-10, -2, -7, -3, -2, -9, -20, -4, -5, -6, 0, 0},
    '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 0}
  };

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_exp(input int i, input int n, input int idx, input int best,
                         input int len, input int mg, input int low);
    vt[i].n = 4'(n);
    for (int j = 0; j < 12; j++) vt[i].sc[j] = 16'(sc_tab[i][j]);
    vt[i].idx  = 4'(idx);
    vt[i].best = 16'(best);
    vt[i].len  = len[0];
    vt[i].mg   = 17'(mg);
    vt[i].low  = low[0];
  endtask

  // Called at a negedge; returns at the negedge following the transfer edge.
  task automatic send_beat(input logic [15:0] d, input logic last);
    int guard = 0;
    score_valid = 1'b1;
    score_data  = d;
    score_last  = last;
    while (!score_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk("ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    score_valid = 1'b0;
    score_last  = 1'b0;
  endtask

  task automatic send_vec(input int i);
    for (int j = 0; j < int'(vt[i].n); j++)
      send_beat(vt[i].sc[j], (j == int'(vt[i].n) - 1));
  endtask

  task automatic check_result(input int i);
    logic [16:0] em;
    logic        el;
`ifdef ARGMAX_MARGIN_EN
    em = vt[i].mg;
    el = vt[i].low;
`else
    em = '0;
    el = 1'b0;
`endif
    chk($sformatf("v%0d result_valid_latency", i), 32'(result_valid), 32'd1);
    chk($sformatf("v%0d output_index", i), 32'(output_index), 32'(vt[i].idx));
    chk($sformatf("v%0d best_score", i), 32'(best_score), 32'(vt[i].best));
    chk($sformatf("v%0d len_err", i), 32'(len_err), 32'(vt[i].len));
    chk($sformatf("v%0d margin", i), 32'(margin), 32'(em));
    chk($sformatf("v%0d low_conf", i), 32'(low_conf), 32'(el));
  endtask

  task automatic apply_vec(input int i);
    send_vec(i);
    check_result(i);
    @(negedge clk);
    chk($sformatf("v%0d hold_one_cycle", i), 32'(result_valid), 32'd0);
    chk($sformatf("v%0d ready_back", i), 32'(score_ready), 32'd1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " score_ready"}, 32'(score_ready), 32'd0);
    chk({tag, " result_valid"}, 32'(result_valid), 32'd0);
    chk({tag, " output_index"}, 32'(output_index), 32'd0);
    chk({tag, " best_score"}, 32'(best_score), 32'd0);
    chk({tag, " len_err"}, 32'(len_err), 32'd0);
    chk({tag, " margin"}, 32'(margin), 32'd0);
    chk({tag, " low_conf"}, 32'(low_conf), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    set_exp(0, 10, 2, 9, 0, 0, 1);
    set_exp(1, 10, 0, -32768, 0, 0, 1);
    set_exp(2, 7, 5, 9, 1, 4, 1);
    set_exp(3, 12, 9, 9, 1, 1, 1);
    set_exp(4, 10, 0, 100, 0, 60, 1);
    set_exp(5, 10, 0, 200, 0, 160, 0);
    set_exp(6, 1, 0, -5, 1, 0, 1);
    set_exp(7, 10, 3, 32767, 0, 65535, 0);
    set_exp(8, 10, 1, -2, 0, 0, 1);
    set_exp(9, 10, 9, 9, 0, 1, 1);

    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;
    chk("ready_at_release", 32'(score_ready), 32'd0);
    @(negedge clk);
    chk("ready_after_release", 32'(score_ready), 32'd1);

    for (int i = 0; i < 9; i++) apply_vec(i);

    // Result held under back-pressure, input side closed.
    result_ready = 1'b0;
    send_vec(2);
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("bp%0d result_valid", k), 32'(result_valid), 32'd1);
      chk($sformatf("bp%0d score_ready", k), 32'(score_ready), 32'd0);
      chk($sformatf("bp%0d output_index", k), 32'(output_index), 32'd5);
      chk($sformatf("bp%0d len_err", k), 32'(len_err), 32'd1);
      @(negedge clk);
    end
    result_ready = 1'b1;
    @(negedge clk);
    chk("bp_release result_valid", 32'(result_valid), 32'd0);
    chk("bp_release score_ready", 32'(score_ready), 32'd1);
    chk("bp_release output_index", 32'(output_index), 32'd5);
    apply_vec(0);

    // Reset after four beats discards the partial vector.
    for (int k = 0; k < 4; k++) send_beat(16'd1000, 1'b0);
    rst = 1'b0;
    #1;
    check_zero("midreset");
    @(negedge clk);
    chk("midreset_hold score_ready", 32'(score_ready), 32'd0);
    rst = 1'b1;
    chk("midreset_release score_ready", 32'(score_ready), 32'd0);
    @(negedge clk);
    chk("midreset_after score_ready", 32'(score_ready), 32'd1);
    apply_vec(9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
